keypad_matrix_emulator: RTL and testbench



---
 rtl/keypad_matrix_emulator.sv | 155 +++++++++++++++
 tb/tb_keypad_matrix_emulator.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_matrix_emulator
// Description : 4x4 keypad stand-in; replays queued key presses with bounce,
//               hold and release gap as a column return to a row scanner.
// Revision    : 1.0
// ============================================================================
module keypad_matrix_emulator #(
    parameter int HOLD_CYCLES   = 1000,
    parameter int BOUNCE_CYCLES = 64,
    parameter int BOUNCE_TOGGLE = 8,
    parameter int GAP_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] fila,
    output logic [3:0] columna,
    output logic       busy,
    output logic       contact
);

    localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int MAX_P  = (MAX_HG > BOUNCE_CYCLES) ? MAX_HG : BOUNCE_CYCLES;
    localparam int CW     = $clog2(MAX_P) + 1;
    localparam int TW     = $clog2(BOUNCE_TOGGLE) + 1;

    localparam logic [CW-1:0] HOLD_LOAD   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BOUNCE_LOAD = CW'(BOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD    = CW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TOG_LAST    = TW'(BOUNCE_TOGGLE - 1);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESS_BOUNCE   = 3'd1,
        HOLD           = 3'd2,
        RELEASE_BOUNCE = 3'd3,
        GAP            = 3'd4
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [TW-1:0] tog, tog_next;
    logic [3:0]    code, code_next;
    logic          contact_next;

    assign key_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Each state loads (length - 1) on entry and leaves when the count hits 0.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        tog_next     = tog;
        code_next    = code;
        contact_next = contact;
        case (state)
            IDLE: begin
                contact_next = 1'b0;
                if (key_valid && key_ready) begin
                    code_next    = key_code;
                    contact_next = 1'b1;
                    tog_next     = '0;
                    if (BOUNCE_CYCLES > 0) begin
                        state_next = PRESS_BOUNCE;
                        cnt_next   = BOUNCE_LOAD;
                    end else begin
                        state_next = HOLD;
                        cnt_next   = HOLD_LOAD;
                    end
                end
            end
            PRESS_BOUNCE, RELEASE_BOUNCE: begin
                if (cnt == '0) begin
                    if (state == PRESS_BOUNCE) begin
                        state_next   = HOLD;
                        cnt_next     = HOLD_LOAD;
                        contact_next = 1'b1;
                    end else begin
                        state_next   = GAP;
                        cnt_next     = GAP_LOAD;
                        contact_next = 1'b0;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                    if (tog == TOG_LAST) begin
                        tog_next     = '0;
                        contact_next = ~contact;
                    end else begin
                        tog_next = tog + TW'(1);
                    end
                end
            end
            HOLD: begin
                contact_next = 1'b1;
                if (cnt == '0) begin
                    contact_next = 1'b0;
                    tog_next     = '0;
                    if (BOUNCE_CYCLES > 0) begin
                        state_next = RELEASE_BOUNCE;
                        cnt_next   = BOUNCE_LOAD;
                    end else begin
                        state_next = GAP;
                        cnt_next   = GAP_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            GAP: begin
                contact_next = 1'b0;
                if (cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                contact_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            tog     <= '0;
            code    <= 4'h0;
            contact <= 1'b0;
            columna <= 4'b0000;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            tog     <= tog_next;
            code    <= code_next;
            contact <= contact_next;
            columna <= (contact && fila[code[3:2]]) ? (4'b0001 << code[1:0]) : 4'b0000;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (HOLD_CYCLES >= 1 && GAP_CYCLES >= 1 && BOUNCE_TOGGLE >= 1 && BOUNCE_CYCLES >= 0)
                else $error("keypad_matrix_emulator: illegal zero timing parameter");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_matrix_emulator
// Description : Scenario bench for two emulator instances (no bounce / bounce)
//               against a timeline model of each key press.
// Revision    : 1.0
// ============================================================================
module tb_keypad_matrix_emulator;

    localparam int H  = 20;
    localparam int G  = 5;
    localparam int T  = 4;
    localparam int BA = 0;
    localparam int BB = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_code = 4'h0;
    logic       key_valid = 1'b0;
    logic [3:0] fila = 4'b0000;

    logic       ready_a, busy_a, contact_a;
    logic [3:0] col_a;
    logic       ready_b, busy_b, contact_b;
    logic [3:0] col_b;

    always #5 clk = ~clk;

    keypad_matrix_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(BA), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G)) dut_a (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .key_ready(ready_a),
        .fila(fila), .columna(col_a), .busy(busy_a), .contact(contact_a));

    keypad_matrix_emulator #(.HOLD_CYCLES(H), .BOUNCE_CYCLES(BB), .BOUNCE_TOGGLE(T), .GAP_CYCLES(G)) dut_b (
        .clk(clk), .rst(rst), .key_code(key_code), .key_valid(key_valid), .key_ready(ready_b),
        .fila(fila), .columna(col_b), .busy(busy_b), .contact(contact_b));

    int n_cmp = 0;
    int n_err = 0;

    // Timeline model: a press is "k cycles since acceptance" and contact is a pure function of k.
    int         m_bounce [2] = '{BA, BB};
    int         m_k      [2] = '{0, 0};
    bit         m_act    [2] = '{1'b0, 1'b0};
    bit         m_acc    [2] = '{1'b0, 1'b0};
    logic [3:0] m_code   [2] = '{4'h0, 4'h0};
    logic       m_cont   [2] = '{1'b0, 1'b0};
    logic [3:0] m_col    [2] = '{4'h0, 4'h0};
    logic       m_rdy    [2] = '{1'b0, 1'b0};

    function automatic logic contact_at(int k, int b);
        if (k < b)         return ((k / T) % 2) == 0;
        if (k < b + H)     return 1'b1;
        if (k < 2 * b + H) return (((k - b - H) / T) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic step();
        bit         acc [2];
        logic [3:0] nc  [2];
        logic [3:0] kc;
        kc = key_code;
        for (int i = 0; i < 2; i++) begin
            acc[i] = key_valid && m_rdy[i] && !rst;
            nc[i]  = (!rst && m_cont[i] && fila[m_code[i][3:2]]) ? (4'b0001 << m_code[i][1:0]) : 4'b0000;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            m_acc[i] = acc[i];
            m_col[i] = nc[i];
            if (rst) begin
                m_act[i]  = 1'b0;
                m_code[i] = 4'h0;
            end else if (acc[i]) begin
                m_act[i]  = 1'b1;
                m_k[i]    = 0;
                m_code[i] = kc;
            end else if (m_act[i]) begin
                m_k[i]++;
                if (m_k[i] >= 2 * m_bounce[i] + H + G) m_act[i] = 1'b0;
            end
            m_cont[i] = m_act[i] && contact_at(m_k[i], m_bounce[i]);
            m_rdy[i]  = !m_act[i] && !rst;
        end
    endtask

    task automatic press(input logic [3:0] c);
        key_code  = c;
        key_valid = 1'b1;
        step();
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_act[0] || m_act[1]) && n < 300) begin
            step();
            n++;
            n_cmp++;
            if (busy_a !== m_act[0] || busy_b !== m_act[1]) begin
                n_err++;
                $display("FAIL idle_busy: got a=%b b=%b expected a=%b b=%b", busy_a, busy_b, m_act[0], m_act[1]);
            end
        end
        n_cmp++;
        if (n >= 300) begin
            n_err++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            step();
            n_cmp++;
            if (col_a !== 4'b0000 || busy_a !== 1'b0 || contact_a !== 1'b0 || ready_a !== 1'b0 || ready_b !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state: got col=%b busy=%b contact=%b ready=%b/%b expected 0000 0 0 0/0",
                         col_a, busy_a, contact_a, ready_a, ready_b);
            end
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_err++;
            $display("FAIL reset_ready: got %b/%b expected 1/1", ready_a, ready_b);
        end
        step();
    endtask

    task automatic test_scan_fila();
        int since, hits;
        bit seen;
        since = 0; hits = 0; seen = 1'b0;
        fila = 4'b0001;
        press(4'h6);
        fila = 4'b0010;
        repeat (40) begin
            step();
            fila = {fila[2:0], fila[3]};
            since++;
            if (col_a === 4'b0100) hits++;
            n_cmp++;
            if (col_a !== m_col[0] || contact_a !== m_cont[0]) begin
                n_err++;
                $display("FAIL scan_col: got col=%b contact=%b expected col=%b contact=%b", col_a, contact_a, m_col[0], m_cont[0]);
            end
            if (!seen && ready_a === 1'b1) begin
                seen = 1'b1;
                n_cmp++;
                if (since != 25) begin
                    n_err++;
                    $display("FAIL scan_latency: got %0d expected 25", since);
                end
            end
        end
        n_cmp++;
        if (hits != 5 || !seen) begin
            n_err++;
            $display("FAIL scan_hits: got %0d hits ready_seen=%b expected 5 hits ready_seen=1", hits, seen);
        end
        wait_idle();
    endtask

    task automatic test_wrong_row();
        int hits;
        hits = 0;
        fila = 4'b0010;
        press(4'hF);
        repeat (30) begin
            step();
            n_cmp++;
            if (col_a !== 4'b0000) begin
                n_err++;
                $display("FAIL wrong_row: got %b expected 0000", col_a);
            end
        end
        wait_idle();
        fila = 4'b1000;
        press(4'hF);
        repeat (30) begin
            step();
            if (col_a === 4'b1000) hits++;
            n_cmp++;
            if (col_a !== m_col[0]) begin
                n_err++;
                $display("FAIL right_row: got %b expected %b", col_a, m_col[0]);
            end
        end
        n_cmp++;
        if (hits != H) begin
            n_err++;
            $display("FAIL right_row_len: got %0d expected %0d", hits, H);
        end
        wait_idle();
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'h0F;
        fila = 4'b0001;
        press(4'h0);
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (contact_b !== pat[i]) begin
                n_err++;
                $display("FAIL bounce_pat[%0d]: got %b expected %b", i, contact_b, pat[i]);
            end
            step();
        end
        while (m_act[1]) begin
            n_cmp++;
            if (col_b !== m_col[1] || contact_b !== m_cont[1] || busy_b !== m_act[1]) begin
                n_err++;
                $display("FAIL bounce_seq: got col=%b contact=%b busy=%b expected col=%b contact=%b busy=%b",
                         col_b, contact_b, busy_b, m_col[1], m_cont[1], m_act[1]);
            end
            step();
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int idx, i1, i2;
        logic prev;
        idx = 0; i1 = -1; i2 = -1; prev = busy_a;
        fila = 4'b1001;
        key_code = 4'h3;
        key_valid = 1'b1;
        while (i2 < 0 && idx < 80) begin
            step();
            idx++;
            if (idx == 1) key_code = 4'hC;
            if (busy_a === 1'b1 && prev === 1'b0) begin
                if (i1 < 0) i1 = idx; else i2 = idx;
            end
            prev = busy_a;
            n_cmp++;
            if (col_a !== m_col[0] || ready_a !== m_rdy[0] || busy_a !== m_act[0]) begin
                n_err++;
                $display("FAIL b2b_seq: got col=%b ready=%b busy=%b expected col=%b ready=%b busy=%b",
                         col_a, ready_a, busy_a, m_col[0], m_rdy[0], m_act[0]);
            end
        end
        key_valid = 1'b0;
        n_cmp++;
        if (i1 != 1 || i2 - i1 != 26) begin
            n_err++;
            $display("FAIL b2b_spacing: got first=%0d gap=%0d expected first=1 gap=26", i1, i2 - i1);
        end
        step();
        n_cmp++;
        if (col_a !== 4'b0001) begin
            n_err++;
            $display("FAIL b2b_code: got %b expected 0001", col_a);
        end
        wait_idle();
    endtask

    task automatic test_mid_reset();
        fila = 4'b0010;
        press(4'h6);
        repeat (5) step();
        n_cmp++;
        if (col_a !== 4'b0100) begin
            n_err++;
            $display("FAIL midrst_pre: got %b expected 0100", col_a);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (col_a !== 4'b0000 || busy_a !== 1'b0 || contact_a !== 1'b0 || busy_b !== 1'b0 || contact_b !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_abort: got col=%b busy=%b/%b contact=%b/%b expected 0000 0/0 0/0",
                     col_a, busy_a, busy_b, contact_a, contact_b);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_ready: got %b/%b expected 1/1", ready_a, ready_b);
        end
        step();
    endtask

    task automatic test_multi_row();
        fila = 4'b0110;
        press(4'h5);
        repeat (3) step();
        n_cmp++;
        if (col_a !== 4'b0010) begin
            n_err++;
            $display("FAIL multi_row_5: got %b expected 0010", col_a);
        end
        wait_idle();
        press(4'hA);
        repeat (3) step();
        n_cmp++;
        if (col_a !== 4'b0100) begin
            n_err++;
            $display("FAIL multi_row_a: got %b expected 0100", col_a);
        end
        wait_idle();
    endtask

    task automatic test_random();
        repeat (1500) begin
            key_valid = ($urandom_range(0, 3) == 0);
            key_code  = 4'($urandom_range(0, 15));
            fila      = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << $urandom_range(0, 3));
            rst       = ($urandom_range(0, 399) == 0);
            step();
            for (int i = 0; i < 2; i++) begin
                n_cmp++;
                if ((i == 0 && (col_a !== m_col[0] || contact_a !== m_cont[0] || busy_a !== m_act[0] || ready_a !== m_rdy[0])) ||
                    (i == 1 && (col_b !== m_col[1] || contact_b !== m_cont[1] || busy_b !== m_act[1] || ready_b !== m_rdy[1]))) begin
                    n_err++;
                    $display("FAIL random_dut%0d: got col=%b contact=%b busy=%b ready=%b expected col=%b contact=%b busy=%b ready=%b",
                             i, (i == 0) ? col_a : col_b, (i == 0) ? contact_a : contact_b,
                             (i == 0) ? busy_a : busy_b, (i == 0) ? ready_a : ready_b,
                             m_col[i], m_cont[i], m_act[i], m_rdy[i]);
                end
            end
        end
        rst = 1'b0;
        key_valid = 1'b0;
        step();
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_scan_fila();
        test_wrong_row();
        test_bounce();
        test_back_to_back();
        test_mid_reset();
        test_multi_row();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
